ps2_host_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard (e.g. 0xED set-LEDs, 0xFF reset) over the same kb_clk/data pair the receive shift register listens on.
- Drives both lines open-drain. Runs on the 2.08 MHz oscillator clock and oversamples the device-generated kb_clk.
- Sits beside the receive path in the piano top level.
- The receive path must ignore traffic while busy=1.

---
 rtl/ps2_host_tx.sv | 216 +++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 command transmitter.
//
// Sends one command byte to the keyboard over the shared kb_clk/data pair.
// Both lines are driven open-drain through *_oe outputs. The device-generated
// kb_clk is oversampled on the 2.08 MHz system clock.
//
// Ports:
//   clk        system clock (2.08 MHz oscillator)
//   reset_n    asynchronous active-low reset
//   kb_clk_in  raw PS/2 clock line level (asynchronous)
//   data_in    raw PS/2 data line level (asynchronous)
//   tx_valid   request to send tx_byte (accepted only while tx_ready)
//   tx_byte    command byte
//   tx_ready   high only when idle
//   kb_clk_oe  1 = pull kb_clk low
//   data_oe    1 = pull data low
//   busy       high whenever a frame is in progress (receive path must ignore)
//   tx_done    one-cycle pulse: frame acknowledged by the device
//   tx_err     one-cycle pulse: NACK or timeout
//
// Build option: define PS2_TX_RETRY_EN to resend a failed frame automatically
// (up to 2 retries) before reporting tx_err.

module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYC     = 209,
   parameter int unsigned RTS_TIMEOUT_CYC = 31200,
   parameter int unsigned BIT_TIMEOUT_CYC = 4160
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       kb_clk_in,
   input  logic       data_in,
   input  logic       tx_valid,
   input  logic [7:0] tx_byte,
   output logic       tx_ready,
   output logic       kb_clk_oe,
   output logic       data_oe,
   output logic       busy,
   output logic       tx_done,
   output logic       tx_err
);

   localparam int unsigned TMAX_RB = (RTS_TIMEOUT_CYC > BIT_TIMEOUT_CYC) ? RTS_TIMEOUT_CYC : BIT_TIMEOUT_CYC;
   localparam int unsigned TMAX    = (TMAX_RB > INHIBIT_CYC) ? TMAX_RB : INHIBIT_CYC;
   localparam int unsigned TW      = $clog2(TMAX + 1);

   localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYC - 1);
   localparam logic [TW-1:0] RTS_LIM  = TW'(RTS_TIMEOUT_CYC);
   localparam logic [TW-1:0] BIT_LIM  = TW'(BIT_TIMEOUT_CYC);

   typedef enum logic [2:0] {
      S_IDLE, S_INHIBIT, S_RTS, S_SHIFT, S_STOP, S_ACK, S_WAIT_IDLE
   } state_t;

   state_t        state, state_nx;
   logic          kb_s1, kb_s2, kb_prev, dt_s1, dt_s2;
   logic          fall;
   logic [TW-1:0] timer;
   logic [3:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          parity, data_drv, nack;
   logic          accept, timeout, fail, succeed, retry, err_nx;
`ifdef PS2_TX_RETRY_EN
   logic [1:0]    retry_cnt;
`endif

   // Line synchronisers; idle bus level is high, so reset to 1 to avoid a
   // spurious fall right after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         kb_s1   <= 1'b1;
         kb_s2   <= 1'b1;
         kb_prev <= 1'b1;
         dt_s1   <= 1'b1;
         dt_s2   <= 1'b1;
      end else begin
         kb_s1   <= kb_clk_in;
         kb_s2   <= kb_s1;
         kb_prev <= kb_s2;
         dt_s1   <= data_in;
         dt_s2   <= dt_s1;
      end
   end

   assign fall = kb_prev & ~kb_s2;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   // Next-state logic. A fall in the same cycle as a timer expiry takes
   // priority because the timeout is only considered when no fall is present.
   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      timeout  = 1'b0;
      succeed  = 1'b0;
      fail     = 1'b0;
      retry    = 1'b0;
      case (state)
         S_IDLE: if (tx_valid) begin
            accept   = 1'b1;
            state_nx = S_INHIBIT;
         end
         S_INHIBIT: if (timer == INH_LAST) state_nx = S_RTS;
         S_RTS: begin
            if (fall) state_nx = S_SHIFT;
            else if (timer == RTS_LIM) timeout = 1'b1;
         end
         S_SHIFT: begin
            if (fall) begin
               if (bit_cnt == 4'd9) state_nx = S_STOP;
            end else if (timer == BIT_LIM) timeout = 1'b1;
         end
         S_STOP: begin
            if (fall) state_nx = S_ACK;
            else if (timer == BIT_LIM) timeout = 1'b1;
         end
         S_ACK: begin
            // ACK bit sampled on fall 11; wait for the device to raise the clock
            if (kb_s2) state_nx = S_WAIT_IDLE;
            else if (timer == BIT_LIM) timeout = 1'b1;
         end
         S_WAIT_IDLE: begin
            if (kb_s2 && dt_s2) begin
               state_nx = S_IDLE;
               if (nack) fail = 1'b1;
               else      succeed = 1'b1;
            end else if (timer == BIT_LIM) timeout = 1'b1;
         end
         default: state_nx = S_IDLE;
      endcase
      if (timeout) fail = 1'b1;
`ifdef PS2_TX_RETRY_EN
      if (fail && retry_cnt != 2'd2) retry = 1'b1;
`endif
      err_nx = fail & ~retry;
      if (fail) state_nx = retry ? S_INHIBIT : S_IDLE;
   end

   // Output logic; leaving INHIBIT/RTS/SHIFT releases the lines in the same
   // cycle, including on timeout and on asynchronous reset.
   always_comb begin
      kb_clk_oe = (state == S_INHIBIT);
      case (state)
         S_INHIBIT: data_oe = (timer == INH_LAST);
         S_RTS:     data_oe = 1'b1;
         S_SHIFT:   data_oe = data_drv;
         default:   data_oe = 1'b0;
      endcase
      busy     = (state != S_IDLE);
      tx_ready = (state == S_IDLE);
   end

   // Datapath: timer, bit counter, shift byte, parity, ack sample, pulses
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer     <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         parity    <= 1'b0;
         data_drv  <= 1'b0;
         nack      <= 1'b0;
         tx_done   <= 1'b0;
         tx_err    <= 1'b0;
`ifdef PS2_TX_RETRY_EN
         retry_cnt <= '0;
`endif
      end else begin
         tx_done <= succeed;
         tx_err  <= err_nx;

         // Timer restarts on every state change and, while the device is
         // clocking, on every fall (gap measurement).
         if (state_nx != state || state == S_IDLE ||
             (fall && (state == S_SHIFT || state == S_STOP)))
            timer <= '0;
         else
            timer <= timer + TW'(1);

         if (accept) begin
            shreg  <= tx_byte;
            parity <= ~^tx_byte;
         end

         if (state_nx == S_INHIBIT && state != S_INHIBIT) begin
            bit_cnt  <= '0;
            data_drv <= 1'b0;
            nack     <= 1'b0;
         end

         case (state)
            S_RTS: if (fall) begin
               data_drv <= ~shreg[0];
               bit_cnt  <= 4'd1;
            end
            S_SHIFT: if (fall) begin
               if (bit_cnt < 4'd8)       data_drv <= ~shreg[bit_cnt[2:0]];
               else if (bit_cnt == 4'd8) data_drv <= ~parity;
               else                      data_drv <= 1'b0;
               bit_cnt <= bit_cnt + 4'd1;
            end
            S_STOP: if (fall) nack <= dt_s2;
            default: ;
         endcase

`ifdef PS2_TX_RETRY_EN
         if (accept)     retry_cnt <= '0;
         else if (retry) retry_cnt <= retry_cnt + 2'd1;
`endif
      end
   end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;
   localparam int unsigned INH   = 209;
   localparam int unsigned BIT_T = 4160;
`ifdef PS2_TX_RETRY_EN
   localparam int unsigned RTS_T = 4000;
   localparam int unsigned ATT   = 3;
`else
   localparam int unsigned RTS_T = 31200;
   localparam int unsigned ATT   = 1;
`endif
   localparam int unsigned H        = 20;
   localparam int unsigned RTS_WAIT = BIT_T + INH + 100;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       tx_valid = 1'b0;
   logic [7:0] tx_byte = '0;
   logic       dev_clk_low = 1'b0;
   logic       dev_data_low = 1'b0;
   logic       kb_clk_in, data_in;
   logic       tx_ready, kb_clk_oe, data_oe, busy, tx_done, tx_err;

   assign kb_clk_in = ~(kb_clk_oe | dev_clk_low);
   assign data_in   = ~(data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYC(INH),
      .RTS_TIMEOUT_CYC(RTS_T),
      .BIT_TIMEOUT_CYC(BIT_T)
   ) dut (
      .clk(clk), .reset_n(reset_n), .kb_clk_in(kb_clk_in), .data_in(data_in),
      .tx_valid(tx_valid), .tx_byte(tx_byte), .tx_ready(tx_ready),
      .kb_clk_oe(kb_clk_oe), .data_oe(data_oe), .busy(busy),
      .tx_done(tx_done), .tx_err(tx_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Bus monitor: cumulative counters sampled away from the active edge
   int   cyc = 0, inh_cyc = 0, start_cyc = 0, inh_ph = 0;
   int   done_n = 0, err_n = 0, both_n = 0, err_oe_bad = 0;
   int   rts_cyc = 0, err_cyc = 0;
   logic prev_kb = 1'b0;

   always @(negedge clk) begin
      if (kb_clk_oe === 1'b1) inh_cyc++;
      if (kb_clk_oe === 1'b1 && data_oe === 1'b1) start_cyc++;
      if (kb_clk_oe === 1'b1 && prev_kb !== 1'b1) inh_ph++;
      if (prev_kb === 1'b1 && kb_clk_oe !== 1'b1) rts_cyc = cyc;
      if (tx_done === 1'b1) done_n++;
      if (tx_err === 1'b1) begin
         err_n++;
         err_cyc = cyc;
         if (kb_clk_oe !== 1'b0 || data_oe !== 1'b0) err_oe_bad++;
      end
      if (tx_done === 1'b1 && tx_err === 1'b1) both_n++;
      prev_kb = kb_clk_oe;
      cyc++;
   end

   // Reference: odd parity bit makes the total number of ones odd
   function automatic bit odd_par(input logic [7:0] b);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      return (ones % 2 == 0);
   endfunction

   // Device model: waits for request-to-send, generates np clock pulses and
   // samples the data line just before each rising edge.
   task automatic dev_frame(input int np, input bit ack, input bit strobe,
                            output logic [9:0] bits, output bit ok);
      ok   = 1'b0;
      bits = '0;
      for (int i = 0; i < int'(RTS_WAIT); i++) begin
         @(negedge clk);
         if (kb_clk_oe === 1'b0 && data_oe === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) return;
      repeat (10) @(negedge clk);
      for (int p = 1; p <= np; p++) begin
         dev_clk_low = 1'b1;
         if (strobe && p == 2) begin
            tx_valid = 1'b1;
            tx_byte  = 8'h55;
         end
         @(negedge clk);
         tx_valid = 1'b0;
         repeat (H - 1) @(negedge clk);
         if (p <= 10) bits[p-1] = data_in;
         dev_clk_low = 1'b0;
         if (p == 10) dev_data_low = ack ? 1'b1 : 1'b0;
         if (p == 11) dev_data_low = 1'b0;
         repeat (H) @(negedge clk);
      end
   endtask

   task automatic request(input logic [7:0] b);
      chk("ready_before_req", tx_ready, 1);
      tx_byte  = b;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_byte  = 8'($urandom);
      chk("busy_after_accept", {tx_ready, busy}, 2'b01);
   endtask

   task automatic run_frame(input logic [7:0] b, input bit ack, input bit par,
                            input bit exp_done, input bit exp_err);
      int d0 = done_n, e0 = err_n, i0 = inh_ph, c0 = inh_cyc, s0 = start_cyc, b0 = both_n;
      int att = ack ? 1 : int'(ATT);
      logic [9:0] bits;
      bit ok;
      request(b);
      for (int a = 0; a < att; a++) begin
         dev_frame(11, ack, 1'b0, bits, ok);
         chk("rts_seen", ok, 1);
         if (ok) chk("frame_line_bits", bits, {1'b1, par, b});
      end
      for (int i = 0; i < 300 && done_n == d0 && err_n == e0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("tx_done_pulses", done_n - d0, exp_done);
      chk("tx_err_pulses", err_n - e0, exp_err);
      chk("inhibit_phases", inh_ph - i0, att);
      chk("inhibit_cycles", inh_cyc - c0, INH * att);
      chk("start_bit_cycles", start_cyc - s0, att);
      chk("done_err_overlap", both_n - b0, 0);
      chk("idle_after_frame", {tx_ready, busy}, 2'b10);
   endtask

   typedef struct {
      logic [7:0] b;
      bit         ack;
      bit         par;
      bit         exp_done;
      bit         exp_err;
   } vec_t;

   initial begin
      vec_t vecs[6];
      logic [9:0] bits;
      bit ok;
      int d0, e0, i0, ob0, t_end, dly;

      vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[1] = '{8'h01, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h80, 1'b1, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{8'hF3, 1'b0, 1'b1, 1'b0, 1'b1};

      // Reset state
      repeat (4) @(negedge clk);
      chk("reset_outputs", {tx_ready, busy, kb_clk_oe, data_oe, tx_done, tx_err}, 6'b100000);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_reset_outputs", {tx_ready, busy, kb_clk_oe, data_oe, tx_done, tx_err}, 6'b100000);

      // Directed vectors
      for (int i = 0; i < 6; i++)
         run_frame(vecs[i].b, vecs[i].ack, vecs[i].par, vecs[i].exp_done, vecs[i].exp_err);

      // Randomised frames against the parity/outcome model
      for (int i = 0; i < 10; i++) begin
         logic [7:0] rb;
         bit rack;
         rb   = 8'($urandom);
         rack = ($urandom_range(0, 3) != 0);
         run_frame(rb, rack, odd_par(rb), rack, !rack);
      end

      // Device never clocks: request-to-send timeout
      d0 = done_n; e0 = err_n; i0 = inh_ph; ob0 = err_oe_bad;
      request(8'hF4);
      for (int i = 0; i < int'(ATT * (INH + RTS_T + 50)) && err_n == e0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      chk("rts_timeout_err", err_n - e0, 1);
      chk("rts_timeout_delay", err_cyc - rts_cyc, RTS_T + 1);
      chk("rts_timeout_lines_released", err_oe_bad - ob0, 0);
      chk("rts_timeout_no_done", done_n - d0, 0);
      chk("rts_timeout_attempts", inh_ph - i0, ATT);
      chk("rts_timeout_ready", tx_ready, 1);

      // Device stops after fall 4; a stray tx_valid mid-frame must be ignored
      d0 = done_n; e0 = err_n; i0 = inh_ph; ob0 = err_oe_bad;
      request(8'h3C);
      t_end = 0;
      for (int a = 0; a < int'(ATT); a++) begin
         dev_frame(4, 1'b1, (a == 0), bits, ok);
         chk("stall_rts_seen", ok, 1);
         t_end = cyc;
      end
      for (int i = 0; i < int'(BIT_T + 100) && err_n == e0; i++) @(negedge clk);
      repeat (3) @(negedge clk);
      dly = err_cyc - (t_end - int'(2 * H));
      chk("bit_timeout_err", err_n - e0, 1);
      chk("bit_timeout_delay_in_range", (dly >= int'(BIT_T) && dly <= int'(BIT_T + 8)), 1);
      chk("bit_timeout_lines_released", err_oe_bad - ob0, 0);
      chk("bit_timeout_no_done", done_n - d0, 0);
      chk("stray_valid_ignored", inh_ph - i0, ATT);

      // Asynchronous reset mid-SHIFT while data is being pulled low
      request(8'h00);
      dev_frame(3, 1'b1, 1'b0, bits, ok);
      chk("reset_test_rts_seen", ok, 1);
      chk("shift_data_driven", data_oe, 1);
      #2 reset_n = 1'b0;
      #1 chk("async_release", {kb_clk_oe, data_oe}, 2'b00);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {tx_ready, busy}, 2'b10);
      run_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
